// File: rtl/usb_tx_pkg.sv
// Shared types and line-state encodings for the USB full-speed transmit path.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SHIFT   = 3'd1,
        S_STUFF   = 3'd2,
        S_EOP_SE0 = 3'd3,
        S_EOP_J   = 3'd4
    } tx_state_t;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam int STUFF_LEN_DEFAULT    = 6;
    localparam int EOP_SE0_BITS_DEFAULT = 2;

    // Only ever applied to J or K; SE0 is never toggled.
    function automatic logic [1:0] nrzi_toggle(input logic [1:0] line);
        return (line == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/flex_pts_sr.sv
// LSB-first parallel-to-serial shift register; load wins over shift.
// serial_out_o is bit 0 of the register, valid one clk after load or shift.
module flex_pts_sr #(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_enable_i,
    input  logic                shift_enable_i,
    input  logic [NUM_BITS-1:0] parallel_in_i,
    output logic                serial_out_o
);

    logic [NUM_BITS-1:0] sr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else if (load_enable_i) begin
            sr_q <= parallel_in_i;
        end else if (shift_enable_i) begin
            sr_q <= {1'b0, sr_q[NUM_BITS-1:1]};
        end
    end

    assign serial_out_o = sr_q[0];

endmodule

// File: rtl/usb_tx_serializer.sv
// USB FS transmit: byte handshake in, bit-stuffed NRZI out with EOP; one line change per bit_tick.
// One-byte holding buffer; tx_ready drops on accept and returns the clk after the byte is loaded.
module usb_tx_serializer
    import usb_tx_pkg::*;
#(
    parameter int STUFF_LEN    = STUFF_LEN_DEFAULT,
    parameter int EOP_SE0_BITS = EOP_SE0_BITS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_tick,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_active,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int OW = $clog2(STUFF_LEN + 1);
    localparam int SW = $clog2(EOP_SE0_BITS + 1);

    tx_state_t   state_q, state_d;
    logic [1:0]  line_q, line_d;
    logic [OW-1:0] ones_q, ones_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [SW-1:0] se0_cnt_q, se0_cnt_d;
    logic        cur_last_q, cur_last_d;
    logic        active_q, active_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [7:0]  buf_dat_q;
    logic        buf_last_q;
    logic        buf_full_q;
    logic        buf_wr;
    logic        buf_free;

    logic        sr_load, sr_shift, sr_bit;
    logic        adv;
    logic        drv_vld, drv_bit;
    logic [OW-1:0] ones_base;

    // The register holds the bits still to be driven; bit 0 goes straight to the line on load.
    flex_pts_sr #(.NUM_BITS(8)) u_sr (
        .clk            (clk),
        .rst            (rst),
        .load_enable_i  (sr_load),
        .shift_enable_i (sr_shift),
        .parallel_in_i  ({1'b0, buf_dat_q[7:1]}),
        .serial_out_o   (sr_bit)
    );

    assign buf_wr = tx_valid && !buf_full_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_dat_q  <= '0;
            buf_last_q <= 1'b0;
            buf_full_q <= 1'b0;
        end else if (buf_wr) begin
            buf_dat_q  <= tx_data;
            buf_last_q <= tx_last;
            buf_full_q <= 1'b1;
        end else if (buf_free) begin
            buf_full_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            line_q     <= LINE_J;
            ones_q     <= '0;
            bit_cnt_q  <= '0;
            se0_cnt_q  <= '0;
            cur_last_q <= 1'b0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            ones_q     <= ones_d;
            bit_cnt_q  <= bit_cnt_d;
            se0_cnt_q  <= se0_cnt_d;
            cur_last_q <= cur_last_d;
            active_q   <= active_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        ones_d     = ones_q;
        bit_cnt_d  = bit_cnt_q;
        se0_cnt_d  = se0_cnt_q;
        cur_last_d = cur_last_q;
        active_d   = active_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        sr_load    = 1'b0;
        sr_shift   = 1'b0;
        buf_free   = 1'b0;
        adv        = 1'b0;
        drv_vld    = 1'b0;
        drv_bit    = 1'b0;
        ones_base  = ones_q;

        if (bit_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (buf_full_q) begin
                        sr_load    = 1'b1;
                        buf_free   = 1'b1;
                        drv_vld    = 1'b1;
                        drv_bit    = buf_dat_q[0];
                        ones_base  = '0;
                        line_d     = LINE_J;
                        bit_cnt_d  = '0;
                        cur_last_d = buf_last_q;
                        active_d   = 1'b1;
                        state_d    = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (ones_q == OW'(STUFF_LEN)) begin
                        line_d  = nrzi_toggle(line_q);
                        ones_d  = '0;
                        state_d = S_STUFF;
                    end else begin
                        adv = 1'b1;
                    end
                end
                S_STUFF: adv = 1'b1;
                S_EOP_SE0: begin
                    if (se0_cnt_q == SW'(EOP_SE0_BITS - 1)) begin
                        line_d  = LINE_J;
                        state_d = S_EOP_J;
                    end else begin
                        se0_cnt_d = se0_cnt_q + SW'(1);
                    end
                end
                S_EOP_J: begin
                    active_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase

            // Shared continuation after a data bit or a stuff bit has had its period.
            if (adv) begin
                if (bit_cnt_q != 3'd7) begin
                    sr_shift  = 1'b1;
                    drv_vld   = 1'b1;
                    drv_bit   = sr_bit;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    state_d   = S_SHIFT;
                end else if (buf_full_q) begin
                    sr_load    = 1'b1;
                    buf_free   = 1'b1;
                    drv_vld    = 1'b1;
                    drv_bit    = buf_dat_q[0];
                    bit_cnt_d  = '0;
                    cur_last_d = buf_last_q;
                    state_d    = S_SHIFT;
                end else begin
                    err_d     = !cur_last_q;
                    line_d    = LINE_SE0;
                    se0_cnt_d = '0;
                    state_d   = S_EOP_SE0;
                end
            end

            if (drv_vld) begin
                line_d = drv_bit ? line_d : nrzi_toggle(line_d);
                ones_d = drv_bit ? ones_base + OW'(1) : '0;
            end
        end
    end

    assign tx_ready  = !buf_full_q;
    assign d_plus    = line_q[1];
    assign d_minus   = line_q[0];
    assign tx_active = active_q;
    assign tx_done   = done_q;
    assign tx_error  = err_q;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Directed vectors for usb_tx_serializer: line symbol sequences, done/error pulses, reset behaviour.
module tb_usb_tx_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_tick = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, d_plus, d_minus, tx_active, tx_done, tx_error;

    usb_tx_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .bit_tick  (bit_tick),
        .tx_data   (tx_data),
        .tx_last   (tx_last),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .d_plus    (d_plus),
        .d_minus   (d_minus),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .tx_error  (tx_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]     b0;
        logic [7:0]     b1;
        logic           two;
        logic           last;
        logic           err;
        logic [3:0]     div;
        logic [7:0]     len;
        logic [191:0]   seq;
    } vec_t;

    vec_t         vecs [6];
    int           checks = 0;
    int           errors = 0;
    int           tick_div = 4;
    int           tcnt = 0;
    logic [191:0] cap = '0;
    int           cap_len = 0;
    int           done_cnt = 0;
    int           err_cnt = 0;

    function automatic logic [7:0] sym(input logic p, input logic m);
        case ({p, m})
            2'b10:   return "J";
            2'b01:   return "K";
            2'b00:   return "S";
            default: return "X";
        endcase
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        while (!tx_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: tx_ready=%0b required 1", tx_ready);
        end
        tx_data  = d;
        tx_last  = l;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    task automatic wait_tick_edge();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bit_tick && n < 50);
        if (!bit_tick) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: bit_tick=%0b required 1", bit_tick);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            tcnt     = (tcnt + 1 >= tick_div) ? 0 : tcnt + 1;
            bit_tick = (tcnt == 0);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bit_tick && tx_active && !rst) begin
                cap = {cap[183:0], sym(d_plus, d_minus)};
                cap_len++;
            end
            if (tx_done) done_cnt++;
            if (tx_error) err_cnt++;
        end
    end

    initial begin
        vecs[0] = '{b0: 8'h80, b1: 8'h00, two: 1'b0, last: 1'b1, err: 1'b0, div: 4'd4,
                    len: 8'd11, seq: "KJKJKJKKSSJ"};
        vecs[1] = '{b0: 8'hFF, b1: 8'h00, two: 1'b0, last: 1'b1, err: 1'b0, div: 4'd4,
                    len: 8'd12, seq: "JJJJJJKKKSSJ"};
        vecs[2] = '{b0: 8'h3F, b1: 8'h01, two: 1'b1, last: 1'b1, err: 1'b0, div: 4'd4,
                    len: 8'd20, seq: "JJJJJJKJKKJKJKJKJSSJ"};
        vecs[3] = '{b0: 8'h00, b1: 8'h00, two: 1'b0, last: 1'b0, err: 1'b1, div: 4'd4,
                    len: 8'd11, seq: "KJKJKJKJSSJ"};
        vecs[4] = '{b0: 8'hC0, b1: 8'h0F, two: 1'b1, last: 1'b1, err: 1'b0, div: 4'd4,
                    len: 8'd20, seq: "KJKJKJJJJJJJKJKJKSSJ"};
        vecs[5] = '{b0: 8'h80, b1: 8'h00, two: 1'b0, last: 1'b1, err: 1'b0, div: 4'd1,
                    len: 8'd11, seq: "KJKJKJKKSSJ"};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_line", {d_plus, d_minus}, 2'b10);
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_active", tx_active, 1'b0);
        chk("rst_pulses", {tx_done, tx_error}, 2'b00);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            int n;
            tick_div = int'(vecs[i].div);
            repeat (8) @(negedge clk);
            cap      = '0;
            cap_len  = 0;
            done_cnt = 0;
            err_cnt  = 0;
            send_byte(vecs[i].b0, vecs[i].two ? 1'b0 : vecs[i].last);
            if (vecs[i].two) send_byte(vecs[i].b1, vecs[i].last);
            n = 0;
            while (done_cnt == 0 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            repeat (12) @(negedge clk);
            chk($sformatf("v%0d_len", i), 192'(cap_len), 192'(vecs[i].len));
            chk($sformatf("v%0d_seq", i), cap, vecs[i].seq);
            chk($sformatf("v%0d_done", i), 192'(done_cnt), 192'd1);
            chk($sformatf("v%0d_err", i), 192'(err_cnt), 192'(vecs[i].err));
            chk($sformatf("v%0d_idle", i), {tx_active, tx_ready, d_plus, d_minus}, 4'b0110);
        end

        // First line change on the first tick after the write; buffer frees on that load
        tick_div = 4;
        repeat (8) @(negedge clk);
        tx_data  = 8'h00;
        tx_last  = 1'b1;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        chk("accept_ready_low", tx_ready, 1'b0);
        chk("accept_line_j", {d_plus, d_minus}, 2'b10);
        wait_tick_edge();
        chk("load_ready_high", tx_ready, 1'b1);
        chk("load_active", tx_active, 1'b1);
        chk("load_first_k", {d_plus, d_minus}, 2'b01);

        // Asynchronous reset mid-byte: line back to J without a clock edge
        wait_tick_edge();
        wait_tick_edge();
        chk("mid_line_k", {d_plus, d_minus}, 2'b01);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_line", {d_plus, d_minus}, 2'b10);
        chk("mid_rst_ready", tx_ready, 1'b1);
        chk("mid_rst_active", tx_active, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (20) @(negedge clk);
        chk("mid_rst_no_eop", {tx_active, d_plus, d_minus, 8'(done_cnt)}, {3'b010, 8'd0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
